seq_mult_bcd: RTL and testbench
===============================

Name: seq_mult_bcd

Overview:
- Parametrised successor to the board-level 8x8 signed multiply/display datapath.
- Accepts two signed WIDTH-bit operands on a start edge and multiplies them by sequential shift-add on magnitudes.
- Converts the product magnitude to DIGITS BCD digits by sequential double-dabble.
- Exposes a WINDOW-digit slice of the result that is scrolled by left/right button edges, ready for the 7-segment mux upstream.

Parameters:
- WIDTH, 8: operand width, two's complement; product width is 2*WIDTH.
- DIGITS, 5: BCD digits held for the product magnitude. Must satisfy 10^DIGITS > 2^(2*WIDTH-2).
- WINDOW, 3: digits visible at once; 1 <= WINDOW <= DIGITS.
- POS_W, max(1, $clog2(DIGITS-WINDOW+1)): derived localparam, width of window_pos.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  synchronous level; a rising edge requests a multiply.
- scroll_l  in  1  synchronous level; a rising edge moves the window toward more-significant digits.
- scroll_r  in  1  synchronous level; a rising edge moves the window toward less-significant digits.
- op_a  in  WIDTH  signed multiplicand, sampled on the accept edge.
- op_b  in  WIDTH  signed multiplier, sampled on the accept edge.
- busy  out  1  high while a multiply/convert is in progress.
- done  out  1  level; high from completion until the next accepted start.
- product  out  2*WIDTH  signed result, valid while done=1.
- neg  out  1  result sign; 0 when product is zero.
- window_pos  out  POS_W  index of the lowest visible digit.
- window_digits  out  4*WINDOW  BCD digits [window_pos+WINDOW-1 : window_pos]; most-significant digit in the top nibble.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, product=0, neg=0, BCD register=0, window_pos=0.
- Reset forces all three edge-detect history flops to 1, so an input held high across reset release produces no edge.
- Edge detection: rise = in & ~in_q, evaluated per input every cycle; holding an input high yields exactly one event.
- States and transitions:
  - IDLE: waits for a start edge.
  - MULT: WIDTH cycles, one shift-add step per cycle.
  - CONV: 2*WIDTH cycles, one double-dabble shift per cycle, with add-3 applied to digits >= 5 before each shift.
  - DONE: holds the result; on a start edge returns to MULT.
- Accept, on edge E with a start edge and state IDLE or DONE:
  - Latch op_a/op_b.
  - Compute magnitudes in WIDTH+1 bits so that -2^(WIDTH-1) is exact.
  - Store sign = a_msb ^ b_msb.
  - Clear done, product, neg and the BCD register; set window_pos=0; busy=1 from E.
- Latency: busy falls and done rises after edge E+3*WIDTH (24 cycles for WIDTH=8). product, neg and BCD become valid on that same edge.
- product is the two's complement of the magnitude when the stored sign is 1 and the magnitude is nonzero; otherwise it equals the magnitude.
- A start edge during MULT or CONV is ignored; the operation is not restarted and no request is queued.
- op_a/op_b changes after accept have no effect on the running operation.
- Scroll, processed in every state including busy:
  - scroll_l edge: window_pos+1, saturating at DIGITS-WINDOW.
  - scroll_r edge: window_pos-1, saturating at 0.
  - Both edges in the same cycle: no change.
  - A start accept takes priority and sets window_pos=0.
- window_digits is combinational from the BCD register and window_pos. It shows all zeros while busy and before the first result.
- Reset mid-MULT/CONV aborts the operation with no done pulse; the next operation needs a fresh start edge.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, MULT, CONV, DONE};
  - BCD_W = 4 constant;
  - function clog2_min1.
- Sub-module bin2bcd_seq (parameters IN_W, DIGITS):
  - ports clk, rst, load, bin_in, busy, bcd_out;
  - performs CONV in IN_W cycles;
  - is instantiated once with IN_W = 2*WIDTH.
- Edge detectors and shift-add stay inline.

Test Plan:
- Default params, op_a=-5, op_b=3, start held high 10 cycles -> exactly one accept; done after 24 edges; product=16'hFFF1, neg=1; window_pos=0 gives window_digits=12'h015.
- op_a=117, op_b=-2 -> product=-234 (16'hFF16), neg=1, BCD=00234. Then op_a=127, op_b=127 -> product=16129, neg=0, BCD=16129.
- op_a=-128, op_b=-128 -> product=16'h4000 (16384), neg=0. op_a=0, op_b=-7 -> product=0, neg=0.
- After 16129, scrolling:
  - three separate scroll_l edges -> window_pos saturates at 2, window_digits=12'h161;
  - one scroll_r edge -> pos=1, window_digits=12'h612;
  - scroll_l and scroll_r rising in the same cycle -> pos unchanged.
- Start edge at MULT cycle 3 with new operands -> ignored, and the original result still arrives at E+24.
- Assert rst during CONV -> all outputs zero at once.
- Hold start high through rst release -> no accept. Drop start, then raise it -> accept proceeds normally.

Source files
------------

// File: rtl/seq_mult_bcd_pkg.sv
// seq_mult_pkg: shared state encoding, digit width and sizing helper for seq_mult_bcd
package seq_mult_pkg;
    typedef enum logic [1:0] {IDLE, MULT, CONV, DONE} state_t;
    localparam int BCD_W = 4;
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/seq_mult_bcd_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle for IN_W cycles after load
//   clk, rst (async, active-high), load (capture bin_in, clear digits),
//   bin_in [IN_W], busy (shifting in progress), bcd_out [4*DIGITS]
module bin2bcd_seq
    import seq_mult_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [IN_W-1:0]           bin_in,
    output logic                      busy,
    output logic [BCD_W*DIGITS-1:0]   bcd_out
);
    localparam int CNT_W = clog2_min1(IN_W);

    logic [IN_W-1:0]         r_sh;
    logic [BCD_W*DIGITS-1:0] r_bcd;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_busy;
    logic [BCD_W*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++)
            w_adj[i*BCD_W +: BCD_W] = (r_bcd[i*BCD_W +: BCD_W] >= 4'd5) ? r_bcd[i*BCD_W +: BCD_W] + 4'd3 : r_bcd[i*BCD_W +: BCD_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (load) begin
            r_sh   <= bin_in;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            {r_bcd, r_sh} <= {w_adj[BCD_W*DIGITS-2:0], r_sh, 1'b0};
            r_cnt         <= r_cnt + 1'b1;
            r_busy        <= (r_cnt != CNT_W'(IN_W-1));
        end
    end

    assign busy    = r_busy;
    assign bcd_out = r_bcd;
endmodule

// File: rtl/seq_mult_bcd.sv
// seq_mult_bcd: signed shift-add multiplier with BCD conversion and a scrollable digit window
//   clk, rst (async, active-high), start/scroll_l/scroll_r (rising-edge requests),
//   op_a/op_b [WIDTH] signed operands, busy, done, product [2*WIDTH], neg,
//   window_pos [POS_W] lowest visible digit, window_digits [4*WINDOW]
module seq_mult_bcd
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DIGITS = 5,
    parameter  int WINDOW = 3,
    localparam int POS_W  = clog2_min1(DIGITS-WINDOW+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    scroll_l,
    input  logic                    scroll_r,
    input  logic [WIDTH-1:0]        op_a,
    input  logic [WIDTH-1:0]        op_b,
    output logic                    busy,
    output logic                    done,
    output logic [2*WIDTH-1:0]      product,
    output logic                    neg,
    output logic [POS_W-1:0]        window_pos,
    output logic [BCD_W*WINDOW-1:0] window_digits
);
    localparam int PW    = 2*WIDTH;
    localparam int CNT_W = clog2_min1(PW);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIGITS-WINDOW);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start_q, r_sl_q, r_sr_q;
    logic [PW-1:0]      r_ma;
    logic [WIDTH:0]     r_mb;
    logic [PW-1:0]      r_acc;
    logic               r_sign;
    logic               r_busy, r_done, r_neg;
    logic [PW-1:0]      r_product;
    logic [POS_W-1:0]   r_pos;

    logic               w_start_rise, w_sl_rise, w_sr_rise, w_accept;
    logic [WIDTH:0]     w_a_ext, w_b_ext, w_mag_a, w_mag_b;
    logic [PW-1:0]      w_acc_next;
    logic               w_load, w_finish, w_conv_busy;
    logic [BCD_W*DIGITS-1:0] w_bcd, w_win_sh;

    assign w_start_rise = start & ~r_start_q;
    assign w_sl_rise    = scroll_l & ~r_sl_q;
    assign w_sr_rise    = scroll_r & ~r_sr_q;
    assign w_accept     = w_start_rise && (r_state == IDLE || r_state == DONE);

    // One extra bit keeps |-2^(WIDTH-1)| exact
    assign w_a_ext = {op_a[WIDTH-1], op_a};
    assign w_b_ext = {op_b[WIDTH-1], op_b};
    assign w_mag_a = op_a[WIDTH-1] ? -w_a_ext : w_a_ext;
    assign w_mag_b = op_b[WIDTH-1] ? -w_b_ext : w_b_ext;

    assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);
    // The converter is loaded with the final sum on the last multiply edge so no cycle is lost
    assign w_load     = (r_state == MULT) && (r_cnt == CNT_W'(WIDTH-1));
    assign w_finish   = (r_state == CONV) && (r_cnt == CNT_W'(PW-1)) && w_conv_busy;

    bin2bcd_seq #(.IN_W(PW), .DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .bin_in  (w_acc_next),
        .busy    (w_conv_busy),
        .bcd_out (w_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_start_q <= 1'b1;
            r_sl_q    <= 1'b1;
            r_sr_q    <= 1'b1;
            r_ma      <= '0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_pos     <= '0;
        end else begin
            r_start_q <= start;
            r_sl_q    <= scroll_l;
            r_sr_q    <= scroll_r;
            if (w_accept)
                r_pos <= '0;
            else if (w_sl_rise && !w_sr_rise && r_pos != POS_MAX)
                r_pos <= r_pos + 1'b1;
            else if (w_sr_rise && !w_sl_rise && r_pos != '0)
                r_pos <= r_pos - 1'b1;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state   <= MULT;
                        r_cnt     <= '0;
                        r_ma      <= PW'(w_mag_a);
                        r_mb      <= w_mag_b;
                        r_acc     <= '0;
                        r_sign    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_product <= '0;
                        r_neg     <= 1'b0;
                    end
                end
                MULT: begin
                    r_acc   <= w_acc_next;
                    r_ma    <= r_ma << 1;
                    r_mb    <= r_mb >> 1;
                    r_cnt   <= w_load ? '0 : r_cnt + 1'b1;
                    r_state <= w_load ? CONV : MULT;
                end
                CONV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= (r_sign && |r_acc) ? -r_acc : r_acc;
                        r_neg     <= r_sign && |r_acc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Digits are hidden until a result is complete, so stale or partial conversions never show
    assign w_win_sh      = w_bcd >> (BCD_W * int'(r_pos));
    assign window_digits = r_done ? w_win_sh[BCD_W*WINDOW-1:0] : '0;
    assign busy          = r_busy;
    assign done          = r_done;
    assign product       = r_product;
    assign neg           = r_neg;
    assign window_pos    = r_pos;
endmodule

// File: tb/tb_seq_mult_bcd.sv
// tb_seq_mult_bcd: directed and random checks of seq_mult_bcd against an arithmetic model
module tb_seq_mult_bcd;
    localparam int WIDTH = 8, DIGITS = 5, WINDOW = 3, POS_W = 2;

    logic clk = 0, rst = 1, start = 0, scroll_l = 0, scroll_r = 0;
    logic [WIDTH-1:0] op_a = '0, op_b = '0;
    logic busy, done, neg;
    logic [2*WIDTH-1:0] product;
    logic [POS_W-1:0] window_pos;
    logic [4*WINDOW-1:0] window_digits;

    int n_tests = 0, n_fail = 0, model_pos = 0, lat = 0;

    seq_mult_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .start(start), .scroll_l(scroll_l), .scroll_r(scroll_r),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .product(product), .neg(neg),
        .window_pos(window_pos), .window_digits(window_digits)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_win(input int mag, input int pos);
        logic [11:0] w = '0;
        for (int i = WINDOW-1; i >= 0; i--) begin
            int p = 1;
            for (int k = 0; k < pos+i; k++) p *= 10;
            w = {w[7:0], 4'((mag / p) % 10)};
        end
        return w;
    endfunction

    task automatic wait_done();
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat >= 9) start = 0;
        end
    endtask

    task automatic run_op(input int a, input int b, input int hold, input bit change);
        int p, mag;
        p = a * b;
        mag = (p < 0) ? -p : p;
        @(negedge clk);
        op_a = a[7:0]; op_b = b[7:0]; start = 1;
        @(negedge clk);
        if (change) begin op_a = 8'($urandom); op_b = 8'($urandom); end
        if (hold <= 1) start = 0;
        chk("busy_after_accept", busy, 1);
        chk("done_cleared", done, 0);
        chk("window_zero_busy", window_digits, 0);
        chk("pos_zero_on_accept", window_pos, 0);
        model_pos = 0;
        lat = 0;
        wait_done();
        start = 0;
        chk("latency", lat, 24);
        chk("product", product, p & 32'hFFFF);
        chk("neg", neg, (p < 0));
        chk("busy_end", busy, 0);
        chk("window", window_digits, exp_win(mag, 0));
    endtask

    task automatic scroll(input bit l, input bit r, input int mag);
        @(negedge clk);
        scroll_l = l; scroll_r = r;
        if (l && !r && model_pos < DIGITS-WINDOW) model_pos++;
        if (r && !l && model_pos > 0) model_pos--;
        @(negedge clk);
        scroll_l = 0; scroll_r = 0;
        chk("scroll_pos", window_pos, model_pos);
        chk("scroll_window", window_digits, exp_win(mag, model_pos));
    endtask

    initial begin
        logic signed [7:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_neg", neg, 0);
        chk("rst_pos", window_pos, 0);
        chk("rst_window", window_digits, 0);
        rst = 0;
        @(negedge clk);

        run_op(-5, 3, 10, 1);
        chk("t1_window", window_digits, 12'h015);
        repeat (3) @(negedge clk);
        chk("t1_single_accept", done, 1);
        run_op(117, -2, 1, 0);
        run_op(127, 127, 1, 1);
        chk("16129_window", window_digits, 12'h129);
        scroll(1, 0, 16129);
        scroll(1, 0, 16129);
        scroll(1, 0, 16129);
        chk("sat_window", window_digits, 12'h161);
        scroll(0, 1, 16129);
        chk("r_window", window_digits, 12'h612);
        scroll(1, 1, 16129);
        chk("both_pos", window_pos, 1);

        run_op(-128, -128, 1, 1);
        run_op(0, -7, 1, 0);
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(int'(ra), int'(rb), 1, 1);
        end

        @(negedge clk);
        op_a = 8'(-100); op_b = 8'(55); start = 1;
        @(negedge clk);
        start = 0;
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        op_a = 8'(9); op_b = 8'(9); start = 1;
        @(negedge clk); lat++;
        start = 0;
        chk("ignored_start_busy", busy, 1);
        wait_done();
        chk("ignored_latency", lat, 24);
        chk("ignored_product", product, (-5500) & 32'hFFFF);
        chk("ignored_neg", neg, 1);
        chk("ignored_window", window_digits, exp_win(5500, 0));

        @(negedge clk);
        op_a = 8'(100); op_b = 8'(100); start = 1;
        @(negedge clk);
        start = 0;
        repeat (12) @(negedge clk);
        chk("conv_busy", busy, 1);
        rst = 1; start = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_neg", neg, 0);
        chk("abort_pos", window_pos, 0);
        chk("abort_window", window_digits, 0);
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("held_start_busy", busy, 0);
        chk("held_start_done", done, 0);
        start = 0;
        run_op(-9, -11, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
